// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN sequencer: opcodes, FSM states, error bits.
package rpn_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_EMIT = 3'd5;
  localparam logic [2:0] OP_DROP = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam int ERR_UNDER = 0;
  localparam int ERR_OVER  = 1;
  localparam int ERR_ILL   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_B,
    S_POP_A,
    S_CALC,
    S_EMIT_OUT,
    S_DROP_W
  } state_t;

  // Two-operand opcodes occupy the low end of the opcode space.
  function automatic logic is_binop(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational two-operand ALU; a is next-of-stack, b is top-of-stack.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // Result is modulo 2**WIDTH; carries and borrows are discarded.
  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// RPN token sequencer driving an external Stack; tracks occupancy locally so
// underflow/overflow are rejected before any stack access is issued.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_full,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       err_flags,
  input  logic             err_clr
);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       err_q, err_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             run_q;
  logic [WIDTH-1:0] alu_res;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (stk_dout),
    .b      (b_q),
    .result (alu_res)
  );

  // Handshake and stack strobes decode straight from registered state/data.
  assign tok_ready = run_q && (state_q == S_IDLE);
  assign stk_push  = (state_q == S_PUSH);
  assign stk_pop   = (state_q == S_POP_B) || (state_q == S_POP_A);
  assign stk_din   = val_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err_flags = err_q;

  // State and datapath registers; run_q keeps tok_ready low during reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      val_q       <= '0;
      b_q         <= '0;
      op_q        <= '0;
      err_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      b_q         <= b_d;
      op_q        <= op_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      run_q       <= 1'b1;
    end
  end

  // Next-state, occupancy and error logic; new errors override err_clr.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    val_d       = val_q;
    b_d         = b_q;
    op_d        = op_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    err_d       = err_clr ? '0 : err_q;

    unique case (state_q)
      S_IDLE: begin
        if (tok_valid && tok_ready) begin
          if (!tok_is_op) begin
            if ((cnt_q == CW'(DEPTH)) || stk_full) begin
              err_d[ERR_OVER] = 1'b1;
            end else begin
              val_d   = tok_data;
              state_d = S_PUSH;
            end
          end else begin
            op_d = tok_data[2:0];
            if (is_binop(tok_data[2:0])) begin
              if (cnt_q < CW'(2)) err_d[ERR_UNDER] = 1'b1;
              else                state_d = S_POP_B;
            end else if ((tok_data[2:0] == OP_EMIT) || (tok_data[2:0] == OP_DROP)) begin
              if (cnt_q == '0) err_d[ERR_UNDER] = 1'b1;
              else             state_d = S_POP_B;
            end else begin
              err_d[ERR_ILL] = 1'b1;
            end
          end
        end
      end
      S_PUSH: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = S_IDLE;
      end
      S_POP_B: begin
        cnt_d = cnt_q - CW'(1);
        if (is_binop(op_q))       state_d = S_POP_A;
        else if (op_q == OP_EMIT) state_d = S_EMIT_OUT;
        else                      state_d = S_DROP_W;
      end
      S_POP_A: begin
        // stk_dout now holds the value popped in POP_B, i.e. the old top.
        cnt_d   = cnt_q - CW'(1);
        b_d     = stk_dout;
        state_d = S_CALC;
      end
      S_CALC: begin
        val_d   = alu_res;
        state_d = S_PUSH;
      end
      S_EMIT_OUT: begin
        res_valid_d = 1'b1;
        res_data_d  = stk_dout;
        state_d     = S_IDLE;
      end
      S_DROP_W: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench: behavioural Stack, reference RPN model and scoreboard.
module tb_rpn_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             tok_valid, tok_ready, tok_is_op;
  logic [WIDTH-1:0] tok_data;
  logic             stk_push, stk_pop, stk_full;
  logic [WIDTH-1:0] stk_din, stk_dout;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [2:0]       err_flags;
  logic             err_clr;

  int tests_run = 0;
  int fails     = 0;
  int push_cnt  = 0;
  int pop_cnt   = 0;
  int res_cnt   = 0;
  logic [WIDTH-1:0] last_res = '0;

  logic [WIDTH-1:0] exp_push[$];
  logic [WIDTH-1:0] exp_res[$];
  logic [WIDTH-1:0] mdl[$];
  logic [2:0]       mdl_err = '0;
  logic [WIDTH-1:0] e_push, e_res;

  always #5 clk = ~clk;

  rpn_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_is_op (tok_is_op),
    .tok_data  (tok_data),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err_flags (err_flags),
    .err_clr   (err_clr)
  );

  // Behavioural Stack: registered dout updated on a pop edge.
  logic [WIDTH-1:0] smem [DEPTH];
  int sp;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp       <= 0;
      stk_dout <= '0;
    end else if (stk_push && sp < DEPTH) begin
      smem[sp] <= stk_din;
      sp       <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= smem[sp-1];
      sp       <= sp - 1;
    end
  end
  assign stk_full = (sp == DEPTH);

  // Scoreboard monitor: compares pushes and results against expected queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (stk_pop) pop_cnt++;
      if (stk_push) begin
        push_cnt++;
        tests_run++;
        if (stk_pop) begin
          fails++;
          $display("FAIL push_pop_overlap push=%b pop=%b required not both", stk_push, stk_pop);
        end else if (exp_push.size() == 0) begin
          fails++;
          $display("FAIL unexpected_push din=%0d required no push", stk_din);
        end else begin
          e_push = exp_push.pop_front();
          if (stk_din !== e_push) begin
            fails++;
            $display("FAIL push_din got=%0d required=%0d", stk_din, e_push);
          end
        end
      end
      if (res_valid) begin
        res_cnt++;
        last_res = res_data;
        tests_run++;
        if (exp_res.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result res_data=%0d required no result", res_data);
        end else begin
          e_res = exp_res.pop_front();
          if (res_data !== e_res) begin
            fails++;
            $display("FAIL result got=%0d required=%0d", res_data, e_res);
          end
        end
      end
    end
  end

  // Reference RPN model applied at token acceptance.
  task automatic model_token(input logic is_op, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] a, b, r;
    logic [2:0] op;
    op = d[2:0];
    r  = '0;
    if (!is_op) begin
      if (mdl.size() == DEPTH) mdl_err[1] = 1'b1;
      else begin mdl.push_back(d); exp_push.push_back(d); end
    end else if (op <= 3'd4) begin
      if (mdl.size() < 2) mdl_err[0] = 1'b1;
      else begin
        b = mdl.pop_back();
        a = mdl.pop_back();
        case (op)
          3'd0: r = a + b;
          3'd1: r = a - b;
          3'd2: r = a & b;
          3'd3: r = a | b;
          default: r = a ^ b;
        endcase
        mdl.push_back(r);
        exp_push.push_back(r);
      end
    end else if (op == 3'd5) begin
      if (mdl.size() == 0) mdl_err[0] = 1'b1;
      else exp_res.push_back(mdl.pop_back());
    end else if (op == 3'd6) begin
      if (mdl.size() == 0) mdl_err[0] = 1'b1;
      else r = mdl.pop_back();
    end else begin
      mdl_err[2] = 1'b1;
    end
  endtask

  task automatic clear_model();
    mdl.delete();
    exp_push.delete();
    exp_res.delete();
    mdl_err = '0;
  endtask

  task automatic send(input logic is_op, input logic [WIDTH-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      tests_run++;
      fails++;
      $display("FAIL send_timeout tok_ready=%b required 1", tok_ready);
    end else begin
      tok_valid = 1'b1;
      tok_is_op = is_op;
      tok_data  = d;
      model_token(is_op, d);
      @(posedge clk);
      #1;
      tok_valid = 1'b0;
      tok_is_op = 1'b0;
      tok_data  = '0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      tests_run++;
      fails++;
      $display("FAIL idle_timeout tok_ready=%b required 1", tok_ready);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    tok_valid = 1'b0;
    err_clr   = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run += 7;
    if (tok_ready !== 1'b0) begin fails++; $display("FAIL reset_tok_ready got=%b required=0", tok_ready); end
    if (stk_push  !== 1'b0) begin fails++; $display("FAIL reset_stk_push got=%b required=0", stk_push); end
    if (stk_pop   !== 1'b0) begin fails++; $display("FAIL reset_stk_pop got=%b required=0", stk_pop); end
    if (stk_din   !== '0)   begin fails++; $display("FAIL reset_stk_din got=%0d required=0", stk_din); end
    if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got=%b required=0", res_valid); end
    if (res_data  !== '0)   begin fails++; $display("FAIL reset_res_data got=%0d required=0", res_data); end
    if (err_flags !== 3'b000) begin fails++; $display("FAIL reset_err got=%b required=000", err_flags); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (tok_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got=%b required=1", tok_ready); end
  endtask

  task automatic test_sub();
    int p0, r0;
    do_reset();
    p0 = push_cnt;
    r0 = res_cnt;
    send(1'b0, 8'd5);
    send(1'b0, 8'd3);
    send(1'b1, 8'd1);
    send(1'b1, 8'd5);
    wait_idle();
    @(negedge clk);
    tests_run += 6;
    if (push_cnt - p0 !== 3) begin fails++; $display("FAIL sub_push_count got=%0d required=3", push_cnt - p0); end
    if (res_cnt - r0 !== 1)  begin fails++; $display("FAIL sub_res_count got=%0d required=1", res_cnt - r0); end
    if (last_res !== 8'd2)   begin fails++; $display("FAIL sub_result got=%0d required=2", last_res); end
    if (err_flags !== 3'b000) begin fails++; $display("FAIL sub_err got=%b required=000", err_flags); end
    if (sp !== 0) begin fails++; $display("FAIL sub_stack_depth got=%0d required=0", sp); end
    if (exp_push.size() != 0 || exp_res.size() != 0) begin
      fails++;
      $display("FAIL sub_drain pending_push=%0d pending_res=%0d required 0 0", exp_push.size(), exp_res.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send(1'b0, 8'd200);
    send(1'b0, 8'd100);
    send(1'b1, 8'd0);
    send(1'b1, 8'd5);
    wait_idle();
    @(negedge clk);
    tests_run += 2;
    if (last_res !== 8'd44)   begin fails++; $display("FAIL wrap_result got=%0d required=44", last_res); end
    if (err_flags !== 3'b000) begin fails++; $display("FAIL wrap_err got=%b required=000", err_flags); end
  endtask

  task automatic test_overflow();
    int p0;
    do_reset();
    p0 = push_cnt;
    for (int i = 1; i <= 9; i++) send(1'b0, 8'(i));
    @(negedge clk);
    tests_run += 3;
    if (err_flags !== 3'b010) begin fails++; $display("FAIL overflow_err got=%b required=010", err_flags); end
    if (push_cnt - p0 !== 8)  begin fails++; $display("FAIL overflow_push_count got=%0d required=8", push_cnt - p0); end
    if (tok_ready !== 1'b1)   begin fails++; $display("FAIL overflow_ready got=%b required=1", tok_ready); end
    send(1'b1, 8'd5);
    wait_idle();
    @(negedge clk);
    tests_run++;
    if (last_res !== 8'd8) begin fails++; $display("FAIL overflow_emit got=%0d required=8", last_res); end
  endtask

  task automatic test_underflow();
    int q0;
    logic [WIDTH-1:0] ops [3];
    ops = '{8'd0, 8'd5, 8'd6};
    do_reset();
    q0 = pop_cnt;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, ops[i]);
      @(negedge clk);
      tests_run++;
      if (tok_ready !== 1'b1) begin fails++; $display("FAIL underflow_ready op=%0d got=%b required=1", ops[i], tok_ready); end
    end
    tests_run += 2;
    if (err_flags !== 3'b001) begin fails++; $display("FAIL underflow_err got=%b required=001", err_flags); end
    if (pop_cnt - q0 !== 0)   begin fails++; $display("FAIL underflow_pops got=%0d required=0", pop_cnt - q0); end
  endtask

  task automatic test_illegal();
    int p0, q0;
    do_reset();
    p0 = push_cnt;
    q0 = pop_cnt;
    send(1'b1, 8'd7);
    @(negedge clk);
    tests_run += 3;
    if (err_flags !== 3'b100) begin fails++; $display("FAIL illegal_err got=%b required=100", err_flags); end
    if (push_cnt - p0 !== 0)  begin fails++; $display("FAIL illegal_push got=%0d required=0", push_cnt - p0); end
    if (pop_cnt - q0 !== 0)   begin fails++; $display("FAIL illegal_pop got=%0d required=0", pop_cnt - q0); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests_run++;
    if (err_flags !== 3'b000) begin fails++; $display("FAIL err_clr got=%b required=000", err_flags); end
    // clear coinciding with a new error: underflow cleared, illegal kept
    send(1'b1, 8'd5);
    err_clr = 1'b1;
    send(1'b1, 8'd7);
    err_clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if (err_flags !== 3'b100) begin fails++; $display("FAIL clr_vs_new got=%b required=100", err_flags); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(1'b0, 8'hF0);
    send(1'b0, 8'h3C);
    send(1'b1, 8'd1);
    @(posedge clk);
    #1;
    tests_run++;
    if (stk_pop !== 1'b1) begin fails++; $display("FAIL mid_pop_a got=%b required=1", stk_pop); end
    rstn = 1'b0;
    #1;
    clear_model();
    tests_run += 5;
    if (tok_ready !== 1'b0) begin fails++; $display("FAIL mid_tok_ready got=%b required=0", tok_ready); end
    if (stk_pop   !== 1'b0) begin fails++; $display("FAIL mid_stk_pop got=%b required=0", stk_pop); end
    if (stk_push  !== 1'b0) begin fails++; $display("FAIL mid_stk_push got=%b required=0", stk_push); end
    if (stk_din   !== '0)   begin fails++; $display("FAIL mid_stk_din got=%0d required=0", stk_din); end
    if (err_flags !== 3'b000) begin fails++; $display("FAIL mid_err got=%b required=000", err_flags); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    send(1'b1, 8'd5);
    wait_idle();
    tests_run++;
    if (err_flags !== 3'b001) begin fails++; $display("FAIL mid_emit_under got=%b required=001", err_flags); end
  endtask

  task automatic test_back_to_back();
    int r;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) send(1'b0, 8'($urandom));
      else       send(1'b1, 8'($urandom_range(0, 6)));
    end
    wait_idle();
    @(negedge clk);
    tests_run += 3;
    if (err_flags !== mdl_err) begin fails++; $display("FAIL b2b_err got=%b required=%b", err_flags, mdl_err); end
    if (sp !== mdl.size())     begin fails++; $display("FAIL b2b_depth got=%0d required=%0d", sp, mdl.size()); end
    if (exp_push.size() != 0 || exp_res.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain pending_push=%0d pending_res=%0d required 0 0", exp_push.size(), exp_res.size());
    end
  endtask

  initial begin
    rstn      = 1'b0;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = '0;
    err_clr   = 1'b0;
    test_reset();
    test_sub();
    test_wrap();
    test_overflow();
    test_underflow();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim_time=%0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
